// File: rtl/axi_lite_mbox_regs.sv
// axi_lite_mbox_regs: mailbox FIFO with status/ctrl/lowmark registers; MBOX_IRQ_EN enables the low-watermark interrupt
module axi_lite_mbox_regs #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [DATA_WIDTH-1:0]   mb_data_o,
    output logic                    mb_valid_o,
    input  logic                    mb_ready_i,
    output logic                    irq_o
);
    localparam int PW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wmask;
    logic [PW-1:0] wptr, rptr;
    logic [PW:0] count;
    logic [1:0] sel;
    logic [7:0] count8, lowmark;
    logic [15:0] status;
    logic ovf, wr, push_req, pop, push, full, empty, ctrl_wr, flush, clr_ovf, irq_en;
    logic unused;

    assign sel      = addr_i[4:3];
    assign wr       = en_i & we_i;
    assign push_req = wr & (sel == 2'd0);
    assign ctrl_wr  = wr & (sel == 2'd2) & be_i[0];
    assign flush    = ctrl_wr & wdata_i[1];
    assign clr_ovf  = ctrl_wr & wdata_i[2];
    assign empty    = count == '0;
    assign full     = count == (PW+1)'(DEPTH);
    assign pop      = !empty & mb_ready_i;
    assign push     = push_req & (!full | pop);
    assign count8   = 8'(count);
    assign status   = {count8, 5'd0, ovf, full, empty};
    assign mb_valid_o = !empty;
    assign mb_data_o  = mem[rptr];
    assign unused   = ^{addr_i[ADDR_WIDTH-1:5], addr_i[2:0]};

    for (genvar i = 0; i < DATA_WIDTH/8; i++) begin : g_mask
        assign wmask[8*i +: 8] = {8{be_i[i]}};
    end

    // Storage: a push lands the byte-masked word at the write pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wptr] <= wdata_i & wmask;
        end
    end

    // Pointers, occupancy and sticky overflow; flush wins over a same-cycle pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop) rptr <= rptr + 1'b1;
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
            if (clr_ovf) ovf <= 1'b0;
            else if (push_req & full & !pop) ovf <= 1'b1;
        end
    end

`ifdef MBOX_IRQ_EN
    // Interrupt enable, low watermark and the registered interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en  <= 1'b0;
            lowmark <= '0;
            irq_o   <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= wdata_i[0];
            if (wr & (sel == 2'd3) & be_i[0]) lowmark <= wdata_i[7:0];
            irq_o <= irq_en & (count8 <= lowmark);
        end
    end
`else
    assign irq_en  = 1'b0;
    assign lowmark = '0;
    assign irq_o   = 1'b0;
`endif

    // Zero-latency read mux; only plain reads return data
    always_comb begin
        rdata_o = (!en_i || we_i) ? '0 :
                  (sel == 2'd1)   ? DATA_WIDTH'(status) :
                  (sel == 2'd2)   ? DATA_WIDTH'(irq_en) :
                  (sel == 2'd3)   ? DATA_WIDTH'(lowmark) : '0;
    end
endmodule

// File: tb/tb_axi_lite_mbox_regs.sv
// tb_axi_lite_mbox_regs: scoreboard bench for the mailbox register block
module tb_axi_lite_mbox_regs;
    logic clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b0, we_i = 1'b0, mb_ready_i = 1'b0;
    logic [63:0] addr_i = '0, wdata_i = '0;
    logic [7:0] be_i = '0;
    logic [63:0] rdata_o, mb_data_o;
    logic mb_valid_o, irq_o;
    int checks = 0, errors = 0;
    logic [63:0] rd_q[$], pop_q[$], obs_exp[$];
    int obs_id[$];

    axi_lite_mbox_regs dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .mb_data_o(mb_data_o),
        .mb_valid_o(mb_valid_o), .mb_ready_i(mb_ready_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic string nm(input int id);
        return id == 0 ? "mb_valid" : id == 1 ? "mb_data" : id == 2 ? "irq" : "rdata_no_read";
    endfunction

    // Monitor: compares every read, every consumer handshake and every queued observation
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (en_i && !we_i) begin
                if (rd_q.size() == 0) check("unexpected_read", 64'd1, 64'd0);
                else check("rdata", rdata_o, rd_q.pop_front());
            end
            if (mb_valid_o && mb_ready_i) begin
                if (pop_q.size() == 0) check("unexpected_pop", 64'd1, 64'd0);
                else check("pop_data", mb_data_o, pop_q.pop_front());
            end
            while (obs_id.size() > 0) begin
                int id;
                id = obs_id.pop_front();
                check(nm(id), id == 0 ? 64'(mb_valid_o) : id == 1 ? mb_data_o :
                              id == 2 ? 64'(irq_o) : rdata_o, obs_exp.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] b);
        en_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d; be_i = b;
        step();
        en_i = 1'b0; we_i = 1'b0; be_i = '0;
    endtask

    task automatic rd(input logic [63:0] a, input logic [63:0] exp);
        en_i = 1'b1; we_i = 1'b0; addr_i = a;
        rd_q.push_back(exp);
        step();
        en_i = 1'b0;
    endtask

    task automatic obs(input int id, input logic [63:0] exp);
        obs_id.push_back(id);
        obs_exp.push_back(exp);
    endtask

    task automatic pop1(input logic [63:0] exp);
        pop_q.push_back(exp);
        mb_ready_i = 1'b1;
        step();
        mb_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] x;
        x = 64'hAAAA_BBBB_CCCC_DDDD;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        // reset state
        obs(0, 0); obs(1, 0); obs(2, 0);
        rd(64'h08, 64'h1);
        rd(64'h10, 64'h0);
        rd(64'h18, 64'h0);
        addr_i = 64'h08;
        obs(3, 0);
        step();
        // masked push
        wr(64'h00, 64'h1122_3344_5566_7788, 8'h0F);
        obs(0, 1); obs(1, 64'h0000_0000_5566_7788);
        rd(64'h08, 64'h0100);
        obs(3, 0);
        wr(64'h08, '1, 8'hFF);
        rd(64'h08, 64'h0100);
        rd(64'h28, 64'h0100);
        rd(64'h0F, 64'h0100);
        rd(64'h00, 64'h0);
        pop1(64'h0000_0000_5566_7788);
        rd(64'h08, 64'h1);
        // overflow and clear
        for (int i = 0; i < 9; i++) wr(64'h00, 64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF);
        obs(1, 64'hA5A5_0000_0000_0000);
        rd(64'h08, 64'h0806);
        wr(64'h10, 64'h4, 8'h01);
        rd(64'h08, 64'h0802);
        // push while full with a pop in the same cycle
        mb_ready_i = 1'b1;
        pop_q.push_back(64'hA5A5_0000_0000_0000);
        wr(64'h00, x, 8'hFF);
        mb_ready_i = 1'b0;
        rd(64'h08, 64'h0802);
        for (int i = 1; i < 8; i++) pop1(64'hA5A5_0000_0000_0000 + 64'(i));
        pop1(x);
        rd(64'h08, 64'h1);
`ifdef MBOX_IRQ_EN
        wr(64'h18, 64'hFFFF_FFFF_FFFF_FF02, 8'hFF);
        rd(64'h18, 64'h2);
        wr(64'h10, 64'h1, 8'h01);
        obs(2, 0);
        rd(64'h10, 64'h1);
        obs(2, 1);
        wr(64'h00, 64'hB0, 8'hFF);
        obs(2, 1);
        wr(64'h00, 64'hB1, 8'hFF);
        obs(2, 1);
        wr(64'h00, 64'hB2, 8'hFF);
        obs(2, 1);
        step();
        obs(2, 0);
        pop1(64'hB0);
        obs(2, 0);
        step();
        obs(2, 1);
        step();
        wr(64'h10, 64'h2, 8'h01);
        step(); step();
        obs(2, 0);
        rd(64'h10, 64'h0);
`else
        wr(64'h18, '1, 8'hFF);
        rd(64'h18, 64'h0);
        wr(64'h10, 64'h1, 8'h01);
        step(); step();
        obs(2, 0);
        rd(64'h10, 64'h0);
`endif
        // flush together with a pop
        for (int i = 0; i < 3; i++) wr(64'h00, 64'hC0DE_0000_0000_0000 + 64'(i), 8'hFF);
        mb_ready_i = 1'b1;
        pop_q.push_back(64'hC0DE_0000_0000_0000);
        wr(64'h10, 64'h2, 8'h01);
        mb_ready_i = 1'b0;
        obs(0, 0);
        rd(64'h08, 64'h1);
        wr(64'h00, '1, 8'hA5);
        obs(0, 1); obs(1, 64'hFF00_FF00_00FF_00FF);
        rd(64'h08, 64'h0100);
        // asynchronous reset mid-operation
        wr(64'h00, 64'h77, 8'hFF);
        #2 rst_ni = 1'b0;
        #1;
        check("async_reset_valid", 64'(mb_valid_o), 64'd0);
        check("async_reset_data", mb_data_o, 64'd0);
        step(); step();
        rst_ni = 1'b1;
        obs(0, 0);
        rd(64'h08, 64'h1);
        step(); step();
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check("pop_q_drained", 64'(pop_q.size()), 64'd0);
        check("obs_q_drained", 64'(obs_id.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
